// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of ready ALU reservation-station
// entries onto the single shared ALU, with a one-entry result register
// presented to the CDB through a valid/ready handshake.
// Optional build macro: ALU_ARB_PERF_EN adds perf_busy/perf_stall counters.

package lc3b_types;
    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;
endpackage

module alu_issue_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_RS    = 4,
    parameter int TAG_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RS-1:0]    rs_req,
    input  lc3b_aluop            rs_aluop [NUM_RS],
    input  logic [15:0]          rs_opa   [NUM_RS],
    input  logic [15:0]          rs_opb   [NUM_RS],
    input  logic [TAG_WIDTH-1:0] rs_tag   [NUM_RS],
    output logic [NUM_RS-1:0]    rs_grant,
    output lc3b_aluop            alu_aluop,
    output logic [15:0]          alu_a,
    output logic [15:0]          alu_b,
    input  logic [15:0]          alu_f,
    output logic                 cdb_valid,
    output logic [15:0]          cdb_data,
    output logic [TAG_WIDTH-1:0] cdb_tag,
    input  logic                 cdb_ready,
    input  logic                 flush
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]          perf_busy,
    output logic [15:0]          perf_stall
`endif
);

    localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic                 found;
    logic                 issue_ok;
    logic                 grant_en;
    logic                 vld_p1;
    logic [15:0]          data_p1;
    logic [TAG_WIDTH-1:0] tag_p1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Reset is folded in so nothing is granted while the block is held in reset.
    assign issue_ok = !vld_p1 || cdb_ready;
    assign grant_en = rst_n && issue_ok && !flush && found;

    // Round-robin search: scan requests starting at rr_ptr, wrapping, first hit wins.
    always_comb begin
        int j;
        found     = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int k = 0; k < NUM_RS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_RS) j = j - NUM_RS;
            if (!found && rs_req[j]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(j);
            end
        end
    end

    // Stage p0: one-hot grant and shared-ALU operand mux (idle ALU sees pass of 0).
    always_comb begin
        rs_grant  = '0;
        alu_aluop = alu_pass;
        alu_a     = 16'h0000;
        alu_b     = 16'h0000;
        if (grant_en) begin
            rs_grant[grant_idx] = 1'b1;
            alu_aluop           = rs_aluop[grant_idx];
            alu_a               = rs_opa[grant_idx];
            alu_b               = rs_opb[grant_idx];
        end
    end

    // Stage p1: result register and pointer; flush beats issue, issue beats drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            tag_p1  <= '0;
            rr_ptr  <= '0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
        end else if (grant_en) begin
            vld_p1  <= 1'b1;
            data_p1 <= alu_f;
            tag_p1  <= rs_tag[grant_idx];
            rr_ptr  <= (grant_idx == PTR_W'(NUM_RS - 1)) ? '0 : grant_idx + PTR_W'(1);
        end else if (vld_p1 && cdb_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign cdb_valid = vld_p1;
    assign cdb_data  = data_p1;
    assign cdb_tag   = tag_p1;

`ifdef ALU_ARB_PERF_EN
    // Saturating utilisation and CDB-stall counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (grant_en)
                perf_busy <= sat_inc(perf_busy);
            if ((|rs_req) && vld_p1 && !cdb_ready)
                perf_stall <= sat_inc(perf_stall);
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Testbench for alu_issue_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_alu_issue_arbiter;
    import lc3b_types::*;

    localparam int N  = 4;
    localparam int TW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    rs_req;
    lc3b_aluop       rs_aluop [N];
    logic [15:0]     rs_opa   [N];
    logic [15:0]     rs_opb   [N];
    logic [TW-1:0]   rs_tag   [N];
    logic [N-1:0]    rs_grant;
    lc3b_aluop       alu_aluop;
    logic [15:0]     alu_a, alu_b, alu_f;
    logic            cdb_valid;
    logic [15:0]     cdb_data;
    logic [TW-1:0]   cdb_tag;
    logic            cdb_ready;
    logic            flush;
`ifdef ALU_ARB_PERF_EN
    logic [15:0]     perf_busy, perf_stall;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int          m_ptr;
    bit          m_vld;
    logic [15:0] m_data;
    logic [TW-1:0] m_tag;
    int          m_busy, m_stall;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.NUM_RS(N), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .rs_req(rs_req), .rs_aluop(rs_aluop),
        .rs_opa(rs_opa), .rs_opb(rs_opb), .rs_tag(rs_tag), .rs_grant(rs_grant),
        .alu_aluop(alu_aluop), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_tag(cdb_tag),
        .cdb_ready(cdb_ready), .flush(flush)
`ifdef ALU_ARB_PERF_EN
        , .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
    );

    function automatic logic [15:0] alu_model(lc3b_aluop op, logic [15:0] a, logic [15:0] b);
        case (op)
            alu_add: return a + b;
            alu_and: return a & b;
            alu_not: return ~a;
            alu_sll: return a << b[3:0];
            alu_srl: return a >> b[3:0];
            alu_sra: return 16'($signed(a) >>> b[3:0]);
            default: return a;
        endcase
    endfunction

    // the shared ALU itself
    always_comb alu_f = alu_model(alu_aluop, alu_a, alu_b);

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // index of the entry that should win this cycle, -1 if none
    function automatic int exp_winner();
        if (!rst_n || flush || (m_vld && !cdb_ready)) return -1;
        for (int k = 0; k < N; k++)
            if (rs_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // check one cycle against the model, then advance model across the edge
    task automatic step();
        int w;
        #1;
        w = exp_winner();
        chk("grant", 32'(rs_grant), (w < 0) ? 32'd0 : (32'd1 << w));
        chk("alu_op", 32'(alu_aluop), (w < 0) ? 32'(alu_pass) : 32'(rs_aluop[w]));
        chk("alu_a", 32'(alu_a), (w < 0) ? 32'd0 : 32'(rs_opa[w]));
        chk("alu_b", 32'(alu_b), (w < 0) ? 32'd0 : 32'(rs_opb[w]));
        chk("cdb_valid", 32'(cdb_valid), 32'(m_vld));
        chk("cdb_data", 32'(cdb_data), 32'(m_data));
        chk("cdb_tag", 32'(cdb_tag), 32'(m_tag));
`ifdef ALU_ARB_PERF_EN
        chk("perf_busy", 32'(perf_busy), 32'(m_busy));
        chk("perf_stall", 32'(perf_stall), 32'(m_stall));
`endif
        @(posedge clk);
        if (!rst_n) begin
            m_vld = 0; m_data = '0; m_tag = '0; m_ptr = 0; m_busy = 0; m_stall = 0;
        end else begin
            if (w >= 0 && m_busy < 16'hFFFF) m_busy++;
            if (|rs_req && m_vld && !cdb_ready && m_stall < 16'hFFFF) m_stall++;
            if (flush) m_vld = 0;
            else if (w >= 0) begin
                m_vld  = 1;
                m_data = alu_model(rs_aluop[w], rs_opa[w], rs_opb[w]);
                m_tag  = rs_tag[w];
                m_ptr  = (w + 1) % N;
            end else if (m_vld && cdb_ready) m_vld = 0;
        end
        @(negedge clk);
    endtask

    task automatic randomize_entries();
        for (int i = 0; i < N; i++) begin
            rs_aluop[i] = lc3b_aluop'($urandom_range(0, 6));
            rs_opa[i]   = 16'($urandom);
            rs_opb[i]   = 16'($urandom);
            rs_tag[i]   = TW'($urandom);
        end
    endtask

    initial begin
        m_ptr = 0; m_vld = 0; m_data = '0; m_tag = '0; m_busy = 0; m_stall = 0;
        rst_n = 0; rs_req = '0; cdb_ready = 1; flush = 0;
        randomize_entries();

        // reset state
        step(); step();
        chk("reset_valid", 32'(cdb_valid), 32'd0);
        chk("reset_data", 32'(cdb_data), 32'd0);
        rst_n = 1;

        // single request, add 3+4 tag 5 on entry 2
        rs_req = 4'b0100; rs_aluop[2] = alu_add; rs_opa[2] = 16'h0003;
        rs_opb[2] = 16'h0004; rs_tag[2] = 3'd5; cdb_ready = 0;
        #1 chk("single_grant", 32'(rs_grant), 32'b0100);
        step();
        rs_req = '0;
        chk("single_valid", 32'(cdb_valid), 32'd1);
        chk("single_data", 32'(cdb_data), 32'h0007);
        chk("single_tag", 32'(cdb_tag), 32'd5);
        cdb_ready = 1;
        step();

        // round-robin with all requesting: pointer is now 3
        randomize_entries();
        rs_req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1 chk("rr_grant", 32'(rs_grant), 32'd1 << ((3 + c) % N));
            step();
        end
        // pointer now 0; back-pressure with 0011
        rs_req = 4'b0011; cdb_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #1 chk("stall_grant", 32'(rs_grant), 32'd0);
            step();
        end
        cdb_ready = 1;
        #1 chk("unstall_grant", 32'(rs_grant), 32'b0001);
        step();
        chk("unstall_valid", 32'(cdb_valid), 32'd1);

        // flush while a result is stalled
        rs_req = 4'b0001; cdb_ready = 0; flush = 1;
        #1 chk("flush_grant", 32'(rs_grant), 32'd0);
        step();
        flush = 0; rs_req = '0;
        chk("flush_valid", 32'(cdb_valid), 32'd0);
        step();

        // reset mid-handshake with pointer at 2
        rs_req = 4'b0010; cdb_ready = 0;
        step();
        rs_req = 4'b1010;
        rst_n = 0;
        #1 chk("rst_grant", 32'(rs_grant), 32'd0);
        step();
        chk("rst_valid", 32'(cdb_valid), 32'd0);
        chk("rst_data", 32'(cdb_data), 32'd0);
        rst_n = 1; cdb_ready = 1;
        #1 chk("post_rst_grant", 32'(rs_grant), 32'b0010);
        step();

        // perf scenario: 10 issues then 4 stalls
        rst_n = 0; step(); rst_n = 1;
        rs_req = 4'b1111; cdb_ready = 1;
        for (int c = 0; c < 10; c++) step();
        cdb_ready = 0;
        for (int c = 0; c < 4; c++) step();
`ifdef ALU_ARB_PERF_EN
        chk("perf_busy_10", 32'(perf_busy), 32'd10);
        chk("perf_stall_4", 32'(perf_stall), 32'd4);
`endif
        cdb_ready = 1;

        // random traffic
        for (int c = 0; c < 400; c++) begin
            randomize_entries();
            rs_req    = N'($urandom);
            cdb_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
